// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line, with a one-entry
// output buffer and a valid/ready handshake.
// Optional even-parity bit between bit 7 and stop: define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | confirming start bit at half bit period
// DATA   | sampling 8 data bits, one per bit period
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, delivering or flagging
// BRK    | line stuck low after a framing error, waiting for idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
`endif
  logic          rx_s;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], rx};

  // Next-state logic for the frame FSM, output buffer and error pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (valid_q && data_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BRK;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            state_d = IDLE;
            // A consumer taking the old byte this cycle frees the buffer.
            if (!valid_q || data_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all receiver state; reset aborts any frame in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 8.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 87;  // pin falling edge to data_valid rise, in cycles
`else
  localparam int LAT = 79;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_start = 0;
  int n_rise, n_valid_cyc, n_ferr, n_ovr, n_perr, last_rise;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte, tallies pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected nothing", data_out);
        end else begin
          check("data_out", int'(data_out), int'(exp_q.pop_front()));
        end
      end
      if (data_valid) n_valid_cyc++;
      if (data_valid && !prev_valid) begin
        n_rise++;
        last_rise = cyc;
      end
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
      if (frame_err || overrun || parity_err)
        check("pulse_exclusive", int'(frame_err) + int'(overrun) + int'(parity_err), 1);
    end
    prev_valid = data_valid;
  end

  task automatic clear_counts();
    n_rise = 0; n_valid_cyc = 0; n_ferr = 0; n_ovr = 0; n_perr = 0; last_rise = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(C);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    frame_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    data_ready = 1'b0;
    clear_counts();
    tick(3);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_data_out",   int'(data_out),   0);
    check("rst_frame_err",  int'(frame_err),  0);
    check("rst_overrun",    int'(overrun),    0);
    check("rst_parity_err", int'(parity_err), 0);
    reset = 1'b0;
    tick(5);

    // Single good frame, consumer always ready.
    data_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    tick(4);
    check("a5_rises",      n_rise, 1);
    check("a5_valid_cyc",  n_valid_cyc, 1);
    check("a5_latency",    last_rise - frame_start, LAT);
    check("a5_no_err",     n_ferr + n_ovr + n_perr, 0);
    check("a5_q_empty",    exp_q.size(), 0);

    // Three-cycle low glitch on the idle line.
    clear_counts();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch_rises",  n_rise, 0);
    check("glitch_no_err", n_ferr + n_ovr + n_perr, 0);
    check("glitch_idle",   int'(dut.state_q), 0);

    // Framing error, long break, then a good frame.
    clear_counts();
    send_frame(8'h3C, even_par(8'h3C), 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(10);
    check("brk_ferr_early", n_ferr, 1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, even_par(8'h81), 1'b1);
    tick(4);
    check("brk_ferr",      n_ferr, 1);
    check("brk_rises",     n_rise, 1);
    check("brk_q_empty",   exp_q.size(), 0);

    // Overrun: consumer stalled across two back-to-back frames.
    data_ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h11);
    send_frame(8'h11, even_par(8'h11), 1'b1);
    send_frame(8'h22, even_par(8'h22), 1'b1);
    tick(4);
    check("ovr_pulses",    n_ovr, 1);
    check("ovr_ferr",      n_ferr + n_perr, 0);
    check("ovr_held_v",    int'(data_valid), 1);
    check("ovr_held_d",    int'(data_out), 8'h11);
    data_ready = 1'b1;
    tick(3);
    check("ovr_consumed",  exp_q.size(), 0);
    check("ovr_cleared",   int'(data_valid), 0);
    check("ovr_rises",     n_rise, 1);

    // Reset mid-frame with a byte still held in the buffer.
    data_ready = 1'b0;
    clear_counts();
    send_frame(8'h33, even_par(8'h33), 1'b1);
    tick(2);
    check("pre_rst_held",  int'(data_valid), 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(C / 2);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", int'(data_valid), 0);
    check("rst_mid_state", int'(dut.state_q), 0);
    tick(2);
    reset = 1'b0;
    rx = 1'b1;
    tick(20);
    data_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, even_par(8'h5A), 1'b1);
    tick(4);
    check("post_rst_rises", n_rise, 1);
    check("post_rst_q",     exp_q.size(), 0);
    check("post_rst_err",   n_ferr + n_ovr + n_perr, 0);

`ifdef UART_RX_PARITY_EN
    // Parity: correct bit delivered, wrong bit flagged and discarded.
    clear_counts();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    tick(4);
    check("par_rises",     n_rise, 1);
    check("par_perr",      n_perr, 1);
    check("par_other_err", n_ferr + n_ovr, 0);
    check("par_q_empty",   exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 framing, LSB first, idle-high line.
- Complement to the chip's UART transmit path. Lets the chip accept bytes from a host over a single input pin in the same clock domain as the I2C and PWM logic.
- Received bytes are held in a one-entry buffer with a valid/ready handshake toward internal register logic.

Parameters:
- CLKS_PER_BIT, 52, clock cycles per bit period (52 is approximately 9600 baud at the 500 kHz chip clock); legal range >= 4.

Ports:
- clock  input  1  chip clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; asynchronous to clock; idle = 1.
- data_out  output  8  received byte; stable while data_valid = 1.
- data_valid  output  1  buffer holds an unconsumed byte.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good byte dropped because the buffer was still full.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when the parity feature is compiled out.

Behaviour:
- rx passes through a 2-FF synchronizer; both flops reset to 1. The sampled signal (rx_s) therefore lags the pin by 2 cycles.
- Bit counter is $clog2(CLKS_PER_BIT) wide; the bit index counter is 3 bits.
- Reset values: data_out = 0, data_valid = 0, all error pulses = 0, FSM = IDLE, counters = 0.
- FSM states and transitions:
  - IDLE: rx_s == 0 -> START, counter cleared.
  - START: at count (CLKS_PER_BIT-1)/2, sample rx_s.
    - 0 -> DATA, counter cleared.
    - 1 -> treat as glitch, return to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index], index++. After bit 7 -> PARITY (feature on) or STOP.
  - PARITY: sample after CLKS_PER_BIT cycles; compare with even parity of the 8 data bits -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles, i.e. mid stop bit.
    - 1 with no parity error -> deliver byte, go to IDLE immediately. This allows back-to-back frames with a single stop bit.
    - 1 with parity error -> parity_err pulse, byte discarded, go to IDLE.
    - 0 -> frame_err pulse, byte discarded, go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. No start detection while in BREAK.
- Delivery, evaluated in the cycle of the stop sample:
  - If data_valid == 0, or data_valid && data_ready in that same cycle: load data_out and set data_valid = 1 on the next edge.
  - Otherwise: overrun pulse on the next edge. The old byte is retained and the new byte is dropped.
- Latency: data_valid rises 1 cycle after the mid-stop sample. Error pulses align to that same edge.
- Handshake:
  - data_valid clears the edge after data_valid && data_ready, unless a new byte is loaded on that same edge, in which case it stays 1 with new data.
  - data_ready while data_valid == 0 is ignored.
- Reset mid-frame aborts the frame immediately: partial byte is lost and data_valid drops. After release, a line held low is treated as a new start edge.
- Error pulses are never asserted simultaneously with each other. Priority: frame_err over parity_err. overrun is only possible on a good frame.

Optional Feature:
- UART_RX_PARITY_EN defined: the frame carries an even-parity bit between bit 7 and stop; the PARITY state is present; parity_err is active.
- Undefined: 8N1 only; PARITY state absent; parity_err tied to 0. The port list is unchanged.

Test Plan:
- All tests use CLKS_PER_BIT = 8. Frames are driven bit-by-bit on rx.
- Frame 0xA5 with stop = 1, data_ready = 1 -> data_out = 0xA5, data_valid high for exactly 1 cycle, arriving 1 cycle after the mid-stop sample; no error pulses.
- Low glitch of 3 cycles on idle rx -> FSM returns to IDLE; no data_valid, no error.
- Frame 0x3C with stop = 0, then rx held low for 40 cycles, then high, then frame 0x81 -> one frame_err pulse; 0x3C not delivered; 0x81 delivered correctly after the line returns high.
- data_ready = 0; frames 0x11 then 0x22 back-to-back -> 0x11 held; one overrun pulse at the second stop; data_ready = 1 consumes 0x11; 0x22 never appears.
- Assert reset during bit 4 of 0xFF -> data_valid = 0 and FSM = IDLE on the reset edge. A subsequent 0x5A frame is received correctly.
- With UART_RX_PARITY_EN: frame 0x07 with parity 1 -> delivered; frame 0x07 with parity 0 -> parity_err pulse, no data_valid.
